// File: rtl/block_counter_bcd_down.sv
// block_counter_bcd_down
//   Two-digit BCD countdown timer (99..00) with an internal prescaler and a
//   load/start/pause/done control FSM. Intended to drive a seven-segment
//   countdown display and to flag expiry to surrounding logic.
//
// Parameters
//   TICK_DIV : clk_50M cycles per count step (>= 2)
//
// Ports
//   clk_50M  in   system clock, rising edge
//   Reset    in   asynchronous active-low reset
//   Load     in   latch Preset (digits > 9 clamp to 9), return to IDLE
//   Preset   in   [7:4] tens BCD, [3:0] ones BCD
//   Start    in   begin / resume counting
//   Pause    in   suspend counting
//   Tens     out  current tens digit
//   Ones     out  current ones digit
//   Tick     out  one-cycle pulse in the cycle a new (decremented) value shows
//   Running  out  high while in RUN
//   Done     out  high while in DONE
//
// Control inputs are level-sampled every edge with priority Load > Pause > Start.
module block_counter_bcd_down #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk_50M,
  input  logic       Reset,
  input  logic       Load,
  input  logic [7:0] Preset,
  input  logic       Start,
  input  logic       Pause,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       Tick,
  output logic       Running,
  output logic       Done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          running_q;
  logic          done_q;
  logic          count_en;
  logic          is_zero;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign is_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  always_comb begin
    state_d  = state_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    count_en = 1'b0;

    if (Load) begin
      tens_d  = clamp_digit(Preset[7:4]);
      ones_d  = clamp_digit(Preset[3:0]);
      presc_d = '0;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            if (is_zero) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
              presc_d = '0;
            end
          end
        end
        S_RUN: begin
          // A pausing cycle is not counted: prescaler holds and no step fires.
          if (Pause) state_d = S_PAUSE;
          else       count_en = 1'b1;
        end
        S_PAUSE: begin
          // The resuming cycle counts, so a pause costs no prescaler time.
          if (Start && !Pause) begin
            state_d  = S_RUN;
            count_en = 1'b1;
          end
        end
        S_DONE: begin
          // Only Load (above) or Reset leaves DONE.
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (count_en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        // 00 is never decremented; RUN normally leaves at 01 -> 00 anyway.
        if (!is_zero) begin
          tick_d = 1'b1;
          if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
          end else begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end
          if (tens_q == 4'd0 && ones_q == 4'd1) state_d = S_DONE;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50M or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      // Status flags are registered copies of the next state so they line
      // up with the state register and the digits.
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign Tens    = tens_q;
  assign Ones    = ones_q;
  assign Tick    = tick_q;
  assign Running = running_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_block_counter_bcd_down.sv
module tb_block_counter_bcd_down;

  localparam int unsigned TICK_DIV = 4;

  logic       clk_50M;
  logic       Reset;
  logic       Load;
  logic [7:0] Preset;
  logic       Start;
  logic       Pause;
  logic [3:0] Tens;
  logic [3:0] Ones;
  logic       Tick;
  logic       Running;
  logic       Done;

  int n_cmp;
  int n_bad;

  block_counter_bcd_down #(.TICK_DIV(TICK_DIV)) dut (
    .clk_50M (clk_50M),
    .Reset   (Reset),
    .Load    (Load),
    .Preset  (Preset),
    .Start   (Start),
    .Pause   (Pause),
    .Tens    (Tens),
    .Ones    (Ones),
    .Tick    (Tick),
    .Running (Running),
    .Done    (Done)
  );

  // ---------------- clock / reset ----------------
  initial clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  // Advance one edge, then settle 1 ns past it for driving and sampling.
  task automatic cyc();
    @(posedge clk_50M);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [7:0] v);
    Preset = v;
    Load   = 1'b1;
    cyc();
    Load   = 1'b0;
  endtask

  task automatic do_start();
    Start = 1'b1;
    cyc();
    Start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b0; Load = 1'b0; Start = 1'b0; Pause = 1'b0; Preset = 8'h00;
    #3;
    if ({Tens, Ones, Tick, Running, Done} !== 11'h000) begin
      n_bad++; $display("FAIL reset_outputs: got %h want %h", {Tens, Ones, Tick, Running, Done}, 11'h000);
    end
    n_cmp++;
    cyc();
    Reset = 1'b1;
    cyc();
    if ({Tens, Ones, Tick, Running, Done} !== 11'h000) begin
      n_bad++; $display("FAIL reset_release_idle: got %h want %h", {Tens, Ones, Tick, Running, Done}, 11'h000);
    end
    n_cmp++;
  endtask

  task automatic test_count_12();
    int ticks;
    int v;
    logic [7:0] exp_v;
    logic [7:0] prev_v;
    ticks = 0;
    do_load(8'h12);
    if ({Tens, Ones} !== 8'h12 || Running !== 1'b0 || Done !== 1'b0) begin
      n_bad++; $display("FAIL load12: got %h r%b d%b want 12 r0 d0", {Tens, Ones}, Running, Done);
    end
    n_cmp++;
    do_start();
    if (Running !== 1'b1 || Tick !== 1'b0 || {Tens, Ones} !== 8'h12) begin
      n_bad++; $display("FAIL start12_running: got r%b t%b %h want r1 t0 12", Running, Tick, {Tens, Ones});
    end
    n_cmp++;
    prev_v = 8'h12;
    for (int i = 1; i <= 12; i++) begin
      v = 12 - i;
      exp_v[7:4] = 4'(v / 10);
      exp_v[3:0] = 4'(v % 10);
      for (int c = 0; c < TICK_DIV; c++) begin
        cyc();
        if (Tick === 1'b1) ticks++;
        if (c < TICK_DIV - 1) begin
          if (Tick !== 1'b0 || {Tens, Ones} !== prev_v) begin
            n_bad++; $display("FAIL count12_hold step%0d c%0d: got t%b %h want t0 %h", i, c, Tick, {Tens, Ones}, prev_v);
          end
          n_cmp++;
        end else begin
          if (Tick !== 1'b1 || {Tens, Ones} !== exp_v || Done !== (v == 0) || Running !== (v != 0)) begin
            n_bad++; $display("FAIL count12_step%0d: got t%b %h r%b d%b want t1 %h r%b d%b",
                              i, Tick, {Tens, Ones}, Running, Done, exp_v, (v != 0), (v == 0));
          end
          n_cmp++;
        end
      end
      prev_v = exp_v;
    end
    // Hold in DONE, Start must not leave it.
    Start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (Tick === 1'b1) ticks++;
    end
    Start = 1'b0;
    if ({Tens, Ones} !== 8'h00 || Done !== 1'b1 || Running !== 1'b0 || Tick !== 1'b0) begin
      n_bad++; $display("FAIL done_hold: got %h d%b r%b t%b want 00 d1 r0 t0", {Tens, Ones}, Done, Running, Tick);
    end
    n_cmp++;
    if (ticks !== 12) begin
      n_bad++; $display("FAIL tick_total: got %0d want %0d", ticks, 12);
    end
    n_cmp++;
  endtask

  task automatic test_borrow();
    do_load(8'h20);
    if (Done !== 1'b0 || {Tens, Ones} !== 8'h20) begin
      n_bad++; $display("FAIL borrow_load: got %h d%b want 20 d0", {Tens, Ones}, Done);
    end
    n_cmp++;
    do_start();
    repeat (TICK_DIV) cyc();
    if ({Tens, Ones} !== 8'h19 || Tick !== 1'b1) begin
      n_bad++; $display("FAIL borrow_step: got %h t%b want 19 t1", {Tens, Ones}, Tick);
    end
    n_cmp++;
    cyc();
    if (Tick !== 1'b0 || {Tens, Ones} !== 8'h19) begin
      n_bad++; $display("FAIL borrow_tick_width: got t%b %h want t0 19", Tick, {Tens, Ones});
    end
    n_cmp++;
    repeat (TICK_DIV - 1) cyc();
    if ({Tens, Ones} !== 8'h18 || Tick !== 1'b1) begin
      n_bad++; $display("FAIL borrow_second: got %h t%b want 18 t1", {Tens, Ones}, Tick);
    end
    n_cmp++;
  endtask

  task automatic test_pause();
    do_load(8'h50);
    do_start();          // prescaler 0
    cyc();               // 1
    cyc();               // 2
    Pause = 1'b1;
    cyc();               // pause sampled with prescaler at 2
    if (Running !== 1'b0 || {Tens, Ones} !== 8'h50) begin
      n_bad++; $display("FAIL pause_enter: got r%b %h want r0 50", Running, {Tens, Ones});
    end
    n_cmp++;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (Running !== 1'b0 || Tick !== 1'b0 || {Tens, Ones} !== 8'h50 || Done !== 1'b0) begin
        n_bad++; $display("FAIL pause_hold c%0d: got r%b t%b %h d%b want r0 t0 50 d0", c, Running, Tick, {Tens, Ones}, Done);
      end
      n_cmp++;
    end
    Pause = 1'b0;
    do_start();          // resume, prescaler 2 -> 3
    if (Running !== 1'b1 || Tick !== 1'b0 || {Tens, Ones} !== 8'h50) begin
      n_bad++; $display("FAIL pause_resume: got r%b t%b %h want r1 t0 50", Running, Tick, {Tens, Ones});
    end
    n_cmp++;
    cyc();
    if (Tick !== 1'b1 || {Tens, Ones} !== 8'h49) begin
      n_bad++; $display("FAIL pause_next_step: got t%b %h want t1 49", Tick, {Tens, Ones});
    end
    n_cmp++;
  endtask

  task automatic test_clamp_and_zero();
    do_load(8'hAF);
    if ({Tens, Ones} !== 8'h99 || Running !== 1'b0 || Done !== 1'b0) begin
      n_bad++; $display("FAIL clamp_af: got %h r%b d%b want 99 r0 d0", {Tens, Ones}, Running, Done);
    end
    n_cmp++;
    do_load(8'h00);
    do_start();
    if (Done !== 1'b1 || Tick !== 1'b0 || Running !== 1'b0 || {Tens, Ones} !== 8'h00) begin
      n_bad++; $display("FAIL zero_start: got d%b t%b r%b %h want d1 t0 r0 00", Done, Tick, Running, {Tens, Ones});
    end
    n_cmp++;
  endtask

  task automatic test_load_priority();
    do_load(8'h37);
    do_start();
    if (Running !== 1'b1) begin
      n_bad++; $display("FAIL prio_run37: got r%b want r1", Running);
    end
    n_cmp++;
    cyc();
    Preset = 8'h05; Load = 1'b1; Start = 1'b1; Pause = 1'b1;
    cyc();
    Load = 1'b0; Start = 1'b0; Pause = 1'b0;
    if ({Tens, Ones} !== 8'h05 || Running !== 1'b0 || Done !== 1'b0 || Tick !== 1'b0) begin
      n_bad++; $display("FAIL prio_load: got %h r%b d%b t%b want 05 r0 d0 t0", {Tens, Ones}, Running, Done, Tick);
    end
    n_cmp++;
    repeat (2 * TICK_DIV) cyc();
    if ({Tens, Ones} !== 8'h05 || Running !== 1'b0) begin
      n_bad++; $display("FAIL prio_idle_hold: got %h r%b want 05 r0", {Tens, Ones}, Running);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    do_load(8'h42);
    do_start();
    cyc();
    Reset = 1'b0;
    #2;
    if ({Tens, Ones, Tick, Running, Done} !== 11'h000) begin
      n_bad++; $display("FAIL reset_mid_async: got %h want %h", {Tens, Ones, Tick, Running, Done}, 11'h000);
    end
    n_cmp++;
    Reset = 1'b1;
    cyc();
    if ({Tens, Ones, Tick, Running, Done} !== 11'h000) begin
      n_bad++; $display("FAIL reset_first_edge: got %h want %h", {Tens, Ones, Tick, Running, Done}, 11'h000);
    end
    n_cmp++;
    do_start();
    if (Done !== 1'b1 || Running !== 1'b0 || Tick !== 1'b0) begin
      n_bad++; $display("FAIL reset_then_start00: got d%b r%b t%b want d1 r0 t0", Done, Running, Tick);
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    // Reload straight out of DONE and run a short count to expiry.
    do_load(8'h02);
    if (Done !== 1'b0 || {Tens, Ones} !== 8'h02) begin
      n_bad++; $display("FAIL b2b_load: got d%b %h want d0 02", Done, {Tens, Ones});
    end
    n_cmp++;
    do_start();
    repeat (2 * TICK_DIV) cyc();
    if ({Tens, Ones} !== 8'h00 || Done !== 1'b1 || Tick !== 1'b1 || Running !== 1'b0) begin
      n_bad++; $display("FAIL b2b_expire: got %h d%b t%b r%b want 00 d1 t1 r0", {Tens, Ones}, Done, Tick, Running);
    end
    n_cmp++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_count_12();
    test_borrow();
    test_pause();
    test_clamp_and_zero();
    test_load_priority();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
